dram_dispatch: RTL and testbench

- Dispatch RAM stage directly downstream of the instruction register/decode logic.
- Consumes the 9-bit dispatch address formed from the loaded IR (opcode plus AC/IO bits) and produces the registered A, B and J dispatch fields and the stored parity bit for the microsequencer.
- Owns the diagnostic load/readback sequencer that writes each 17-bit entry as three 6-bit EBUS transfers on EBUS bits 12-17.

---
 rtl/dram_pkg.sv | 34 +++
 rtl/dram_load_seq.sv | 72 +++++++
 rtl/dram_dispatch.sv | 126 ++++++++++++
 tb/tb_dram_dispatch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the dispatch RAM stage.
//   - dram_entry_t : stored 17-bit entry {A[2:0], B[2:0], P, J}.
//                    J is held J01-first: j[10] is J01, j[1] is J10, so the
//                    J field reads left to right as J01..J10.
//   - load_state_t : diagnostic loader FSM states.
//   - SEL_*        : readback portion selects for diag_sel_h.
//   - ADDR_W_DEF / J_W_DEF : default widths used by the top level.
// Optional feature macro used by the top level: DRAM_PARITY_CHECK_EN.
package dram_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int J_W_DEF    = 10;
    localparam int ENTRY_W    = 17;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        logic        p;
        logic [10:1] j;
    } dram_entry_t;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_GOT_AB  = 2'd1,
        LD_GOT_JHI = 2'd2,
        LD_WRITE   = 2'd3
    } load_state_t;

    localparam logic [1:0] SEL_AB   = 2'd0;  // {A, B}
    localparam logic [1:0] SEL_PJHI = 2'd1;  // {P, J01..J05}
    localparam logic [1:0] SEL_JLO  = 2'd2;  // {J06..J10, 0}
    localparam logic [1:0] SEL_ZERO = 2'd3;  // all zero

endpackage

// File: rtl/dram_load_seq.sv
// dram_load_seq: diagnostic loader for the dispatch RAM.
// Collects one entry as three 6-bit EBUS portions, then spends one WRITE
// cycle presenting it to the RAM.
// Ports:
//   clk_h, reset_h  : clock, synchronous active-high reset
//   diag_load_h     : one-cycle strobe, accept diag_data_h as next portion
//   diag_data_h[5:0]: EBUS d12-17 portion
//   wr_en           : high for the single WRITE cycle
//   wr_entry        : staged entry to be written
//   state           : current loader state (debug visibility)
//   seq_err         : sticky, a portion arrived during WRITE
// Handshake: diag_load_h has no back-pressure; every strobe is consumed in
// the cycle it is high. A strobe in WRITE is dropped and flagged in seq_err.
module dram_load_seq
    import dram_pkg::*;
(
    input  logic        clk_h,
    input  logic        reset_h,
    input  logic        diag_load_h,
    input  logic [5:0]  diag_data_h,
    output logic        wr_en,
    output dram_entry_t wr_entry,
    output load_state_t state,
    output logic        seq_err
);

    load_state_t state_next;
    dram_entry_t stage;

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state <= LD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        case (state)
            LD_IDLE:    if (diag_load_h) state_next = LD_GOT_AB;
            LD_GOT_AB:  if (diag_load_h) state_next = LD_GOT_JHI;
            LD_GOT_JHI: if (diag_load_h) state_next = LD_WRITE;
            LD_WRITE: begin
                wr_en      = 1'b1;
                state_next = LD_IDLE;
            end
            default:    state_next = LD_IDLE;
        endcase
    end

    // Staging registers; reset discards a partial entry so nothing is written.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            stage   <= '0;
            seq_err <= 1'b0;
        end else if (diag_load_h) begin
            case (state)
                LD_IDLE:    {stage.a, stage.b}     <= diag_data_h;
                LD_GOT_AB:  {stage.p, stage.j[10:6]} <= diag_data_h;
                // bit 0 of the third portion carries nothing
                LD_GOT_JHI: stage.j[5:1]           <= diag_data_h[5:1];
                LD_WRITE:   seq_err                <= 1'b1;
                default:    ;
            endcase
        end
    end

    assign wr_entry = stage;

endmodule

// File: rtl/dram_dispatch.sv
// dram_dispatch: dispatch RAM stage after IR decode.
// Holds a 512 x 17 dispatch RAM, the registered A/B/J/P output word, a
// write-through bypass for a coincident loader write, and the EBUS
// readback mux. The diagnostic loader lives in dram_load_seq.
// Ports:
//   clk_h, reset_h          : clock, synchronous active-high reset
//   dram_addr_h             : dispatch address from IR decode
//   con_load_dram_l         : active-low, capture RAM[dram_addr_h] on outputs
//   diag_addr_h             : diagnostic write/readback address
//   diag_load_h/diag_data_h : loader portion strobe and data
//   diag_read_h/diag_sel_h  : readback enable and portion select
//   dram_a_h/b_h/j_h        : registered A, B, J (J01 at MSB)
//   dram_odd_parity_h       : stored parity bit
//   dram_par_err_h          : entry fails odd parity (only with the macro)
//   ebus_d_h                : readback data, zero when diag_read_h low
//   load_busy_h             : loader mid-sequence
//   load_seq_err_h          : sticky out-of-sequence load
// Optional feature macro: DRAM_PARITY_CHECK_EN (parity error output).
module dram_dispatch
    import dram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int J_W    = J_W_DEF
) (
    input  logic              clk_h,
    input  logic              reset_h,
    input  logic [ADDR_W-1:0] dram_addr_h,
    input  logic              con_load_dram_l,
    input  logic [ADDR_W-1:0] diag_addr_h,
    input  logic              diag_load_h,
    input  logic [5:0]        diag_data_h,
    input  logic              diag_read_h,
    input  logic [1:0]        diag_sel_h,
    output logic [2:0]        dram_a_h,
    output logic [2:0]        dram_b_h,
    output logic [J_W-1:0]    dram_j_h,
    output logic              dram_odd_parity_h,
    output logic              dram_par_err_h,
    output logic [5:0]        ebus_d_h,
    output logic              load_busy_h,
    output logic              load_seq_err_h
);

    dram_entry_t mem [2**ADDR_W];
    dram_entry_t out_q;
    dram_entry_t rd_entry;
    dram_entry_t rb_entry;
    dram_entry_t wr_entry;
    logic        wr_en;
    load_state_t load_state;

    dram_load_seq u_load_seq (
        .clk_h       (clk_h),
        .reset_h     (reset_h),
        .diag_load_h (diag_load_h),
        .diag_data_h (diag_data_h),
        .wr_en       (wr_en),
        .wr_entry    (wr_entry),
        .state       (load_state),
        .seq_err     (load_seq_err_h)
    );

    assign load_busy_h = (load_state != LD_IDLE);

    // RAM contents survive reset.
    always_ff @(posedge clk_h) begin
        if (wr_en) begin
            mem[diag_addr_h] <= wr_entry;
        end
    end

    // A read landing on the entry being written sees the new value.
    always_comb begin
        rd_entry = mem[dram_addr_h];
        if (wr_en && (diag_addr_h == dram_addr_h)) begin
            rd_entry = wr_entry;
        end
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            out_q <= '0;
        end else if (!con_load_dram_l) begin
            out_q <= rd_entry;
        end
    end

    assign dram_a_h          = out_q.a;
    assign dram_b_h          = out_q.b;
    assign dram_j_h          = out_q.j;
    assign dram_odd_parity_h = out_q.p;

`ifdef DRAM_PARITY_CHECK_EN
    logic par_err_q;

    // Even population over A, B, P, J means the entry broke odd parity.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            par_err_q <= 1'b0;
        end else if (!con_load_dram_l) begin
            par_err_q <= ~(^rd_entry);
        end
    end

    assign dram_par_err_h = par_err_q;
`else
    assign dram_par_err_h = 1'b0;
`endif

    // Readback looks at the RAM array only, so a WRITE-cycle read shows
    // the pre-write contents.
    assign rb_entry = mem[diag_addr_h];

    always_comb begin
        ebus_d_h = '0;
        if (diag_read_h) begin
            case (diag_sel_h)
                SEL_AB:   ebus_d_h = {rb_entry.a, rb_entry.b};
                SEL_PJHI: ebus_d_h = {rb_entry.p, rb_entry.j[10:6]};
                SEL_JLO:  ebus_d_h = {rb_entry.j[5:1], 1'b0};
                default:  ebus_d_h = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_dispatch.sv
// tb_dram_dispatch: directed plus randomized checks of dram_dispatch.
// The reference model keeps, per address, the three EBUS portions that
// were loaded; all expected fields are derived from those portions.
module tb_dram_dispatch;

    logic       clk_h = 1'b0;
    logic       reset_h;
    logic [8:0] dram_addr_h;
    logic       con_load_dram_l;
    logic [8:0] diag_addr_h;
    logic       diag_load_h;
    logic [5:0] diag_data_h;
    logic       diag_read_h;
    logic [1:0] diag_sel_h;
    logic [2:0] dram_a_h;
    logic [2:0] dram_b_h;
    logic [9:0] dram_j_h;
    logic       dram_odd_parity_h;
    logic       dram_par_err_h;
    logic [5:0] ebus_d_h;
    logic       load_busy_h;
    logic       load_seq_err_h;

    int total = 0;
    int bad   = 0;

    // reference model: loaded portions per address (third portion bit 0 masked)
    logic [5:0] m_d1 [512];
    logic [5:0] m_d2 [512];
    logic [5:0] m_d3 [512];
    logic [16:0] exp_q [$];
    logic [8:0]  addr_q [$];

    dram_dispatch dut (
        .clk_h             (clk_h),
        .reset_h           (reset_h),
        .dram_addr_h       (dram_addr_h),
        .con_load_dram_l   (con_load_dram_l),
        .diag_addr_h       (diag_addr_h),
        .diag_load_h       (diag_load_h),
        .diag_data_h       (diag_data_h),
        .diag_read_h       (diag_read_h),
        .diag_sel_h        (diag_sel_h),
        .dram_a_h          (dram_a_h),
        .dram_b_h          (dram_b_h),
        .dram_j_h          (dram_j_h),
        .dram_odd_parity_h (dram_odd_parity_h),
        .dram_par_err_h    (dram_par_err_h),
        .ebus_d_h          (ebus_d_h),
        .load_busy_h       (load_busy_h),
        .load_seq_err_h    (load_seq_err_h)
    );

    // clock / reset block
    always #5 clk_h = ~clk_h;

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // expected parity error: an even number of ones over the whole entry
    function automatic logic exp_par(input logic [5:0] d1, input logic [5:0] d2, input logic [5:0] d3);
`ifdef DRAM_PARITY_CHECK_EN
        return (($countones(d1) + $countones(d2) + $countones(d3[5:1])) % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    // expected output word {A, B, P, J01..J10} from the model at addr
    function automatic logic [16:0] model_word(input logic [8:0] addr);
        logic [2:0] a;
        logic [2:0] b;
        logic       p;
        logic [9:0] j;
        a = m_d1[addr] / 8;
        b = m_d1[addr] % 8;
        p = m_d2[addr] >= 6'd32;
        j = (10'(m_d2[addr] % 32) * 32) + 10'(m_d3[addr] / 2);
        return {a, b, p, j};
    endfunction

    task automatic commit(input logic [8:0] addr, input logic [5:0] d1, input logic [5:0] d2, input logic [5:0] d3);
        m_d1[addr] = d1;
        m_d2[addr] = d2;
        m_d3[addr] = d3 & 6'b111110;
    endtask

    // drive three portions; returns just after the edge that enters WRITE
    task automatic start_load(input logic [8:0] addr, input logic [5:0] d1, input logic [5:0] d2, input logic [5:0] d3);
        diag_addr_h = addr;
        diag_load_h = 1'b1;
        diag_data_h = d1;
        tick();
        check("busy_after_p1", load_busy_h, 1'b1);
        diag_data_h = d2;
        tick();
        diag_data_h = d3;
        tick();
        diag_load_h = 1'b0;
        diag_data_h = $urandom_range(0, 63);
        check("busy_in_write", load_busy_h, 1'b1);
    endtask

    task automatic load_entry(input logic [8:0] addr, input logic [5:0] d1, input logic [5:0] d2, input logic [5:0] d3);
        start_load(addr, d1, d2, d3);
        tick();
        commit(addr, d1, d2, d3);
        check("busy_after_write", load_busy_h, 1'b0);
    endtask

    // compare registered outputs against the head of the expected queue
    task automatic check_out(input string tag);
        logic [16:0] w;
        w = exp_q.pop_front();
        check({tag, "_a"}, dram_a_h, w[16:14]);
        check({tag, "_b"}, dram_b_h, w[13:11]);
        check({tag, "_p"}, dram_odd_parity_h, w[10]);
        check({tag, "_j"}, dram_j_h, w[9:0]);
        check({tag, "_perr"}, dram_par_err_h,
              ($countones(w) % 2) == 0 ? exp_par(6'd0, 6'd0, 6'd0) : 1'b0);
    endtask

    task automatic read_entry(input logic [8:0] addr, input string tag);
        con_load_dram_l = 1'b0;
        dram_addr_h     = addr;
        exp_q.push_back(model_word(addr));
        tick();
        con_load_dram_l = 1'b1;
        dram_addr_h     = $urandom_range(0, 511);
        check_out(tag);
    endtask

    task automatic check_rb(input logic [8:0] addr);
        logic [5:0] want;
        for (int s = 0; s < 4; s++) begin
            diag_read_h = 1'b1;
            diag_addr_h = addr;
            diag_sel_h  = 2'(s);
            #1;
            want = (s == 0) ? m_d1[addr] : (s == 1) ? m_d2[addr] : (s == 2) ? m_d3[addr] : 6'd0;
            check($sformatf("rb_sel%0d", s), ebus_d_h, want);
        end
        diag_read_h = 1'b0;
        #1;
        check("rb_gated", ebus_d_h, 6'd0);
    endtask

    initial begin
        logic [8:0] ra;
        logic [5:0] r1, r2, r3;

        reset_h         = 1'b1;
        dram_addr_h     = '0;
        con_load_dram_l = 1'b1;
        diag_addr_h     = '0;
        diag_load_h     = 1'b0;
        diag_data_h     = '0;
        diag_read_h     = 1'b0;
        diag_sel_h      = '0;
        tick();
        tick();
        check("rst_a", dram_a_h, 3'd0);
        check("rst_b", dram_b_h, 3'd0);
        check("rst_j", dram_j_h, 10'd0);
        check("rst_p", dram_odd_parity_h, 1'b0);
        check("rst_perr", dram_par_err_h, 1'b0);
        check("rst_busy", load_busy_h, 1'b0);
        check("rst_err", load_seq_err_h, 1'b0);
        check("rst_ebus", ebus_d_h, 6'd0);
        reset_h = 1'b0;
        tick();

        // 1: load sequence and dispatch read
        load_entry(9'o254, 6'o52, 6'o37, 6'o25);
        read_entry(9'o254, "t1");
        check("t1_a_const", dram_a_h, 3'd5);
        check("t1_b_const", dram_b_h, 3'd2);
        check("t1_p_const", dram_odd_parity_h, 1'b0);
        check("t1_jhi_const", dram_j_h[9:5], 5'b11111);

        // 2: readback portions
        check_rb(9'o254);

        // 3: bypass on same address, old contents on a different address
        load_entry(9'o100, 6'o11, 6'o22, 6'o33);
        load_entry(9'o101, 6'o44, 6'o55, 6'o66);
        start_load(9'o100, 6'o71, 6'o62, 6'o53);
        diag_read_h     = 1'b1;
        diag_sel_h      = 2'd0;
        con_load_dram_l = 1'b0;
        dram_addr_h     = 9'o100;
        #1;
        check("t3_rb_prewrite", ebus_d_h, m_d1[9'o100]);
        commit(9'o100, 6'o71, 6'o62, 6'o53);
        exp_q.push_back(model_word(9'o100));
        tick();
        con_load_dram_l = 1'b1;
        diag_read_h     = 1'b0;
        check_out("t3_bypass");
        start_load(9'o100, 6'o17, 6'o40, 6'o77);
        con_load_dram_l = 1'b0;
        dram_addr_h     = 9'o101;
        exp_q.push_back(model_word(9'o101));
        tick();
        con_load_dram_l = 1'b1;
        commit(9'o100, 6'o17, 6'o40, 6'o77);
        check_out("t3_other");
        read_entry(9'o100, "t3_after");

        // 4: a fourth portion landing in WRITE
        start_load(9'o200, 6'o12, 6'o34, 6'o56);
        diag_load_h = 1'b1;
        diag_data_h = 6'o77;
        tick();
        diag_load_h = 1'b0;
        commit(9'o200, 6'o12, 6'o34, 6'o56);
        check("t4_err", load_seq_err_h, 1'b1);
        check("t4_busy", load_busy_h, 1'b0);
        tick();
        check("t4_err_sticky", load_seq_err_h, 1'b1);
        check("t4_still_idle", load_busy_h, 1'b0);
        read_entry(9'o200, "t4");

        // 5: reset after two portions
        diag_addr_h = 9'o254;
        diag_load_h = 1'b1;
        diag_data_h = 6'o00;
        tick();
        diag_data_h = 6'o00;
        tick();
        diag_load_h = 1'b0;
        reset_h     = 1'b1;
        tick();
        reset_h     = 1'b0;
        check("t5_busy", load_busy_h, 1'b0);
        check("t5_err_clr", load_seq_err_h, 1'b0);
        check("t5_out_a", dram_a_h, 3'd0);
        check("t5_out_j", dram_j_h, 10'd0);
        tick();
        check("t5_busy_hold", load_busy_h, 1'b0);
        read_entry(9'o254, "t5_unchanged");
        load_entry(9'o255, 6'o61, 6'o02, 6'o43);
        read_entry(9'o255, "t5_fresh");

        // 6: parity edge cases
        load_entry(9'o300, 6'o00, 6'o00, 6'o00);
        read_entry(9'o300, "t6_p0");
        check("t6_perr_p0", dram_par_err_h, exp_par(6'o00, 6'o00, 6'o00));
        load_entry(9'o301, 6'o00, 6'o40, 6'o01);
        read_entry(9'o301, "t6_p1");
        check("t6_perr_p1", dram_par_err_h, 1'b0);

        // randomized loads, reads and readback
        for (int i = 0; i < 40; i++) begin
            ra = 9'($urandom_range(0, 511));
            r1 = 6'($urandom_range(0, 63));
            r2 = 6'($urandom_range(0, 63));
            r3 = 6'($urandom_range(0, 63));
            load_entry(ra, r1, r2, r3);
            addr_q.push_back(ra);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        for (int i = 0; i < 20; i++) begin
            ra = addr_q[$urandom_range(0, addr_q.size() - 1)];
            read_entry(ra, "rnd_rd");
            if (i % 4 == 0) check_rb(ra);
        end
        check("rnd_err_clear", load_seq_err_h, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
